// File: rtl/fpu_pkg.sv
// Shared float-format constants, status bit positions and the converter state type.
// Used by both the integer-to-float encoder and the downstream adder.
package fpu_pkg;

   localparam int BIAS   = 31;
   localparam int EXP_W  = 6;
   localparam int MANT_W = 25;

   localparam int ST_ZERO    = 0;
   localparam int ST_INEXACT = 1;
   localparam int ST_NEG     = 2;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      PACK
   } conv_state_t;

endpackage

// File: rtl/fp_from_int.sv
// Serial integer-to-float encoder: sign/magnitude split, one-bit-per-cycle normalisation, pack.
// Define FP_ROUND_NEAREST_EN to round to nearest-even in PACK instead of truncating.
import fpu_pkg::*;

module fp_from_int #(
   parameter int INT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [INT_W-1:0] int_in,
   output logic             busy,
   output logic             done,
   output logic [31:0]      data_out,
   output logic [3:0]       status_out
);

   conv_state_t      r_state;
   conv_state_t      w_nextState;
   logic [INT_W-1:0] r_mag;
   logic [EXP_W-1:0] r_expCnt;
   logic             r_sign;

   logic             w_load;
   logic             w_shift;
   logic             w_pack;
   logic             w_isZero;
   logic             w_normDone;
   logic [INT_W-1:0] w_absIn;

   logic [INT_W+25:0]  w_fracExt;
   logic [MANT_W-1:0]  w_mantTrunc;
   logic [MANT_W-1:0]  w_mant;
   logic [EXP_W-1:0]   w_expField;
   logic [EXP_W-1:0]   w_expOut;
   logic               w_guard;
   logic               w_sticky;
   logic [31:0]        w_packed;
   logic [3:0]         w_status;

   assign w_isZero   = (r_mag == '0);
   assign w_normDone = w_isZero | r_mag[INT_W-1];
   assign w_absIn    = int_in[INT_W-1] ? -int_in : int_in;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = NORM;
         NORM:    if (w_normDone) w_nextState = PACK;
         PACK:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      busy    = (r_state != IDLE);
      w_load  = (r_state == IDLE) && start;
      w_shift = (r_state == NORM) && !w_normDone;
      w_pack  = (r_state == PACK);
   end

   // Fraction below the hidden one, left-aligned with two spare zero bits so guard
   // and sticky exist even when the fraction is narrower than the mantissa.
   assign w_fracExt   = {r_mag[INT_W-2:0], 27'b0};
   assign w_mantTrunc = w_fracExt[INT_W+25 -: MANT_W];
   assign w_guard     = w_fracExt[INT_W];
   assign w_sticky    = |w_fracExt[INT_W-1:0];
   assign w_expField  = r_expCnt + EXP_W'(BIAS);

`ifdef FP_ROUND_NEAREST_EN
   logic              w_roundUp;
   logic [MANT_W:0]   w_mantSum;

   assign w_roundUp = w_guard & (w_sticky | w_mantTrunc[0]);
   assign w_mantSum = {1'b0, w_mantTrunc} + (MANT_W+1)'(w_roundUp);
   assign w_mant    = w_mantSum[MANT_W-1:0];
   assign w_expOut  = w_expField + EXP_W'(w_mantSum[MANT_W]);
`else
   assign w_mant    = w_mantTrunc;
   assign w_expOut  = w_expField;
`endif

   always_comb begin
      w_status              = '0;
      w_status[ST_ZERO]     = w_isZero;
      w_status[ST_INEXACT]  = !w_isZero && (w_guard || w_sticky);
      w_status[ST_NEG]      = !w_isZero && r_sign;
      w_packed              = w_isZero ? 32'h0 : {r_sign, w_expOut, w_mant};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mag      <= '0;
         r_expCnt   <= '0;
         r_sign     <= 1'b0;
         data_out   <= '0;
         status_out <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (w_load) begin
            r_sign   <= int_in[INT_W-1];
            r_mag    <= w_absIn;
            r_expCnt <= EXP_W'(INT_W-1);
         end else if (w_shift) begin
            r_mag    <= {r_mag[INT_W-2:0], 1'b0};
            r_expCnt <= r_expCnt - EXP_W'(1);
         end
         if (w_pack) begin
            data_out   <= w_packed;
            status_out <= w_status;
            done       <= 1'b1;
         end
      end
   end

endmodule
